// File: rtl/jetpack_pkg.sv
// Shared geometry, colours and helpers for the Joyride Jetpack game engine.
// Every rectangle is half-open [lo,hi). Overlap tests use 11-bit coordinates so that right and bottom edges cannot overflow.
package jetpack_pkg;

  localparam int WIDTH_DEF   = 640;
  localparam int HEIGHT_DEF  = 480;

  localparam int PLAYER_X0   = 20;
  localparam int PLAYER_W    = 10;
  localparam int PLAYER_H    = 10;

  localparam int OBST_W      = 16;
  localparam int OBST_H      = 120;
  localparam int OBST_Y0_RST = 200;
  localparam int OBST_Y_OFS  = 40;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t COL_PLAYER  = 24'hFFFF00;
  localparam rgb_t COL_OBST    = 24'hFF0000;
  localparam rgb_t COL_BG      = 24'h000040;
  localparam rgb_t COL_BG_OVER = 24'h400000;
  localparam rgb_t COL_BLACK   = 24'h000000;

  // Fibonacci LFSR, taps 8,6,5,4 (maximal length, never reaches zero from a non-zero seed)
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic span_overlap(input logic [10:0] a_lo, input logic [10:0] a_hi,
                                        input logic [10:0] b_lo, input logic [10:0] b_hi);
    return (a_lo < b_hi) && (b_lo < a_hi);
  endfunction

endpackage

// File: rtl/jetpack_game_core_tick_gen.sv
// Physics pacing: a free-running divider produces a tick on each rising edge of the selected bit.
// A mod-SPEED_DIV tick counter then raises upd for one clk every SPEED_DIV ticks.
module tick_gen #(
  parameter int TICK_BIT  = 11,
  parameter int SPEED_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  output logic upd
);

  localparam int DW = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;

  // Counter bits above TICK_BIT never affect the tick, so the counter stops at TICK_BIT.
  logic [TICK_BIT:0] cnt;
  logic              cnt_msb_q;
  logic [DW-1:0]     tick_cnt;
  logic              tick;

  assign tick = cnt[TICK_BIT] & ~cnt_msb_q;
  assign upd  = tick && (tick_cnt == DW'(SPEED_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      cnt_msb_q <= 1'b0;
      tick_cnt  <= '0;
    end else begin
      cnt       <= cnt + 1'b1;
      cnt_msb_q <= cnt[TICK_BIT];
      if (tick) tick_cnt <= upd ? '0 : tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jetpack_game_core.sv
// Game engine: player physics, one scrolling obstacle, a sticky collision flag and a per-pixel colour mux.
// State advances on each upd strobe. Colour is combinational from (x,y), so it reaches the output in the same cycle.
module jetpack_game_core
  import jetpack_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int HEIGHT    = HEIGHT_DEF,
  parameter int TICK_BIT  = 11,
  parameter int SPEED_DIV = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fly,
  input  logic [9:0] x,
  input  logic [8:0] y,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic [8:0] y0,
  output logic       game_over
);

  localparam logic [9:0]  X_LIM  = 10'(WIDTH);
  localparam logic [8:0]  Y_LIM  = 9'(HEIGHT);
  localparam logic [8:0]  Y0_RST = 9'(HEIGHT / 2);
  localparam logic [8:0]  Y0_MAX = 9'(HEIGHT - PLAYER_H);
  localparam logic [10:0] PX_LO  = 11'(PLAYER_X0);
  localparam logic [10:0] PX_HI  = 11'(PLAYER_X0 + PLAYER_W);

  logic        upd;
  logic [9:0]  obs_x;
  logic [8:0]  obs_y0;
  logic [7:0]  lfsr;
  logic        hit;
  logic [10:0] obs_x_lo, obs_x_hi;
  logic [10:0] y0_lo, y0_hi;
  logic [10:0] obs_y_lo, obs_y_hi;
  logic [10:0] px, py;
  rgb_t        pix;

  tick_gen #(
    .TICK_BIT  (TICK_BIT),
    .SPEED_DIV (SPEED_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .upd   (upd)
  );

  assign obs_x_lo = {1'b0, obs_x};
  assign obs_x_hi = obs_x_lo + 11'(OBST_W);
  assign y0_lo    = {2'b00, y0};
  assign y0_hi    = y0_lo + 11'(PLAYER_H);
  assign obs_y_lo = {2'b00, obs_y0};
  assign obs_y_hi = obs_y_lo + 11'(OBST_H);
  assign px       = {1'b0, x};
  assign py       = {2'b00, y};

  assign hit = span_overlap(PX_LO, PX_HI, obs_x_lo, obs_x_hi) &&
               span_overlap(y0_lo, y0_hi, obs_y_lo, obs_y_hi);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y0        <= Y0_RST;
      obs_x     <= X_LIM;
      obs_y0    <= 9'(OBST_Y0_RST);
      lfsr      <= LFSR_SEED;
      game_over <= 1'b0;
    end else begin
      lfsr <= lfsr_next(lfsr);
      if (hit) game_over <= 1'b1;
      // A collision freezes the scene until reset.
      if (upd && !game_over) begin
        if (fly) begin
          if (y0 != '0) y0 <= y0 - 1'b1;
        end else if (y0 < Y0_MAX) begin
          y0 <= y0 + 1'b1;
        end
        if (obs_x == '0) begin
          obs_x  <= X_LIM;
          obs_y0 <= {1'b0, lfsr} + 9'(OBST_Y_OFS);
        end else begin
          obs_x <= obs_x - 1'b1;
        end
      end
    end
  end

  always_comb begin
    pix = COL_BLACK;
    if (x < X_LIM && y < Y_LIM) begin
      if (px >= PX_LO && px < PX_HI && py >= y0_lo && py < y0_hi)
        pix = COL_PLAYER;
      else if (px >= obs_x_lo && px < obs_x_hi && py >= obs_y_lo && py < obs_y_hi)
        pix = COL_OBST;
      else if (game_over)
        pix = COL_BG_OVER;
      else
        pix = COL_BG;
    end
  end

  assign r = pix.r;
  assign g = pix.g;
  assign b = pix.b;

endmodule

// File: tb/tb_jetpack_game_core.sv
// Checks jetpack_game_core against a frame-level model that applies one physics update per 8-clk period.
module tb_jetpack_game_core;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fly = 1'b0;
  logic [9:0] x = '0;
  logic [8:0] y = '0;
  logic [7:0] r, g, b;
  logic [8:0] y0;
  logic       game_over;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: game state after N updates
  int m_y0, m_obs_x, m_obs_y0, m_go, m_known;

  always #5 clk = ~clk;

  jetpack_game_core #(
    .WIDTH(640), .HEIGHT(480), .TICK_BIT(1), .SPEED_DIV(2)
  ) dut (
    .clk(clk), .reset(reset), .fly(fly), .x(x), .y(y),
    .r(r), .g(g), .b(b), .y0(y0), .game_over(game_over)
  );

  task automatic model_reset();
    m_y0 = 240; m_obs_x = 640; m_obs_y0 = 200; m_go = 0; m_known = 1;
  endtask

  task automatic model_upd(input logic f);
    if (m_go == 0) begin
      if (f) m_y0 = (m_y0 > 0) ? m_y0 - 1 : 0;
      else   m_y0 = (m_y0 < 470) ? m_y0 + 1 : 470;
      if (m_obs_x == 0) begin m_obs_x = 640; m_known = 0; end
      else m_obs_x = m_obs_x - 1;
    end
    if (m_known != 0 && m_obs_x < 30 && m_obs_x + 16 > 20 &&
        m_y0 < m_obs_y0 + 120 && m_y0 + 10 > m_obs_y0) m_go = 1;
  endtask

  function automatic logic [23:0] model_rgb(input int px, input int py);
    if (px >= 640 || py >= 480) return 24'h000000;
    if (px >= 20 && px < 30 && py >= m_y0 && py < m_y0 + 10) return 24'hFFFF00;
    if (m_obs_x < 640 && px >= m_obs_x && px < m_obs_x + 16 &&
        py >= m_obs_y0 && py < m_obs_y0 + 120) return 24'hFF0000;
    return (m_go != 0) ? 24'h400000 : 24'h000040;
  endfunction

  // Release lands 2 clks before a sampling point; updates then fall 5..6 clks into each 8-clk period.
  task automatic do_reset();
    reset = 1'b1;
    fly   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic run_period(input logic f);
    fly = f;
    repeat (8) @(posedge clk);
    #1;
    model_upd(f);
  endtask

  task automatic test_reset();
    int          px[12] = '{25, 100, 700, 20, 29, 19, 30, 25, 25, 639, 10, 640};
    int          py[12] = '{245, 100, 10, 240, 249, 245, 245, 250, 239, 479, 480, 0};
    logic [23:0] pe[12] = '{24'hFFFF00, 24'h000040, 24'h000000, 24'hFFFF00, 24'hFFFF00, 24'h000040,
                            24'h000040, 24'h000040, 24'h000040, 24'h000040, 24'h000000, 24'h000000};
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (y0 !== 9'd240) begin n_fail++; $display("FAIL reset_y0: got %0d want 240", y0); end
    n_checks++;
    if (game_over !== 1'b0) begin n_fail++; $display("FAIL reset_game_over: got %b want 0", game_over); end
    do_reset();
    for (int i = 0; i < 12; i++) begin
      x = 10'(px[i]); y = 9'(py[i]); #1;
      n_checks++;
      if ({r, g, b} !== pe[i]) begin
        n_fail++;
        $display("FAIL reset_pixel (%0d,%0d): got %h want %h", px[i], py[i], {r, g, b}, pe[i]);
      end
    end
  endtask

  task automatic test_fall_and_wrap();
    int px, py, first, last, cnt;
    do_reset();
    for (int p = 1; p <= 640; p++) begin
      run_period(1'b0);
      n_checks++;
      if (y0 !== 9'(m_y0)) begin n_fail++; $display("FAIL fall_y0 period %0d: got %0d want %0d", p, y0, m_y0); end
      if (p % 32 == 0) begin
        for (int i = 0; i < 3; i++) begin
          px = $urandom_range(0, 700); py = $urandom_range(0, 511);
          x = 10'(px); y = 9'(py); #1;
          n_checks++;
          if ({r, g, b} !== model_rgb(px, py)) begin
            n_fail++;
            $display("FAIL fall_pixel (%0d,%0d): got %h want %h", px, py, {r, g, b}, model_rgb(px, py));
          end
        end
      end
    end
    n_checks++;
    if (game_over !== 1'b0) begin n_fail++; $display("FAIL fall_game_over: got %b want 0", game_over); end
    // obs_x is 0 here: bar occupies columns 0..15, rows 200..319
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin px = 0;  py = 200; end
        1: begin px = 15; py = 319; end
        2: begin px = 16; py = 200; end
        3: begin px = 0;  py = 199; end
        4: begin px = 0;  py = 320; end
        default: begin px = 25; py = 475; end
      endcase
      x = 10'(px); y = 9'(py); #1;
      n_checks++;
      if ({r, g, b} !== model_rgb(px, py)) begin
        n_fail++;
        $display("FAIL wrap_edge (%0d,%0d): got %h want %h", px, py, {r, g, b}, model_rgb(px, py));
      end
    end
    run_period(1'b0);
    x = 10'd0; y = 9'd200; #1;
    n_checks++;
    if ({r, g, b} !== 24'h000040) begin n_fail++; $display("FAIL wrap_offscreen: got %h want 000040", {r, g, b}); end
    run_period(1'b0);
    // Bar now starts at column 639; scan that column for the new vertical band (scan spans 12 updates, bar stays over 639)
    first = -1; last = -1; cnt = 0;
    for (int yy = 0; yy < 480; yy++) begin
      x = 10'd639; y = 9'(yy); #2;
      if ({r, g, b} === 24'hFF0000) begin
        cnt++;
        if (first < 0) first = yy;
        last = yy;
      end
    end
    n_checks++;
    if (cnt != 120 || last - first != 119) begin
      n_fail++; $display("FAIL wrap_bar_height: got %0d rows (%0d..%0d) want 120 contiguous", cnt, first, last);
    end
    n_checks++;
    if (first < 40 || first > 295) begin n_fail++; $display("FAIL wrap_bar_y0: got %0d want 40..295", first); end
  endtask

  task automatic test_fly_up();
    do_reset();
    for (int p = 1; p <= 250; p++) begin
      run_period(1'b1);
      n_checks++;
      if (y0 !== 9'(m_y0)) begin n_fail++; $display("FAIL fly_y0 period %0d: got %0d want %0d", p, y0, m_y0); end
    end
    x = 10'd25; y = 9'd5; #1;
    n_checks++;
    if ({r, g, b} !== 24'hFFFF00) begin n_fail++; $display("FAIL fly_top_pixel: got %h want FFFF00", {r, g, b}); end
  endtask

  task automatic test_collision();
    logic f;
    int   prev, upd_c, go_c, px, py;
    do_reset();
    for (int p = 1; p <= 620; p++) begin
      if (m_y0 >= 250)      f = 1'b1;
      else if (m_y0 <= 230) f = 1'b0;
      else                  f = 1'($urandom_range(0, 1));
      if (m_obs_x == 30 && m_go == 0) begin
        // The overlap starts in this period: game_over must rise exactly one clk after the update edge.
        fly = f; prev = int'(y0); upd_c = -1; go_c = -1;
        for (int c = 1; c <= 8; c++) begin
          @(posedge clk); #1;
          if (upd_c < 0 && int'(y0) != prev) upd_c = c;
          if (go_c < 0 && game_over === 1'b1) go_c = c;
        end
        model_upd(f);
        n_checks++;
        if (upd_c < 0 || go_c != upd_c + 1) begin
          n_fail++; $display("FAIL collide_latency: update clk %0d, game_over clk %0d, want one clk apart", upd_c, go_c);
        end
      end else begin
        run_period(f);
      end
      n_checks++;
      if (y0 !== 9'(m_y0)) begin n_fail++; $display("FAIL collide_y0 period %0d: got %0d want %0d", p, y0, m_y0); end
      n_checks++;
      if (game_over !== 1'(m_go)) begin
        n_fail++; $display("FAIL collide_game_over period %0d: got %b want %0d", p, game_over, m_go);
      end
      if (p % 40 == 0 || p > 612) begin
        px = $urandom_range(0, 60); py = $urandom_range(180, 340);
        x = 10'(px); y = 9'(py); #1;
        n_checks++;
        if ({r, g, b} !== model_rgb(px, py)) begin
          n_fail++;
          $display("FAIL collide_pixel (%0d,%0d): got %h want %h", px, py, {r, g, b}, model_rgb(px, py));
        end
      end
    end
    // Scene frozen with the bar at column 29, rows 200..319
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin px = 29;  py = 201; end
        1: begin px = 28;  py = 201; end
        2: begin px = 44;  py = 201; end
        3: begin px = 45;  py = 201; end
        default: begin px = 100; py = 100; end
      endcase
      x = 10'(px); y = 9'(py); #1;
      n_checks++;
      if ({r, g, b} !== (((i % 2) == 0 && i < 4) ? 24'hFF0000 : 24'h400000)) begin
        n_fail++; $display("FAIL frozen_pixel (%0d,%0d): got %h", px, py, {r, g, b});
      end
    end
  endtask

  task automatic test_midgame_reset();
    reset = 1'b1;
    #2;
    n_checks++;
    if (y0 !== 9'd240) begin n_fail++; $display("FAIL midreset_y0: got %0d want 240", y0); end
    n_checks++;
    if (game_over !== 1'b0) begin n_fail++; $display("FAIL midreset_game_over: got %b want 0", game_over); end
    x = 10'd29; y = 9'd201; #1;
    n_checks++;
    if ({r, g, b} !== 24'h000040) begin n_fail++; $display("FAIL midreset_obs_gone: got %h want 000040", {r, g, b}); end
    do_reset();
    for (int p = 1; p <= 3; p++) run_period(1'b0);
    n_checks++;
    if (y0 !== 9'd243) begin n_fail++; $display("FAIL restart_y0: got %0d want 243", y0); end
    n_checks++;
    if (game_over !== 1'b0) begin n_fail++; $display("FAIL restart_game_over: got %b want 0", game_over); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_fall_and_wrap();
    test_fly_up();
    test_collision();
    test_midgame_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
